// File: rtl/dmem_sized.sv
// dmem_sized: byte-addressable data memory with a request/ready handshake,
// one-cycle registered load responses, illegal-access reporting and a
// zero-fill sweep of the whole array after every reset.
module dmem_sized #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rd,
  output logic        err,
  output logic        init_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_ptr;
  logic [31:0]        r_mem [DEPTH];
  logic               r_rvalid;
  logic               r_err;
  logic [31:0]        r_rd;

  logic [ADDR_W-1:0]  w_idx;
  logic [1:0]         w_lane;
  logic               w_oor;
  logic               w_misal;
  logic               w_illegal;
  logic               w_acc;
  logic               w_store;
  logic [3:0]         w_be;
  logic [31:0]        w_wdat;
  logic [31:0]        w_word;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [31:0]        w_load;

  assign w_idx   = a[ADDR_W+1:2];
  assign w_lane  = a[1:0];
  assign w_oor   = |a[31:ADDR_W+2];
  assign w_acc   = req & ready;
  assign w_store = w_acc & we & ~w_illegal;

  // Legality check: out of range, reserved size, or misaligned half/word.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_misal = 1'b0;
    case (size_t'(size))
      SZ_BYTE: w_misal = 1'b0;
      SZ_HALF: w_misal = a[0];
      SZ_WORD: w_misal = |a[1:0];
      default: w_misal = 1'b1;
    endcase
    w_illegal = w_oor | w_misal;
  end

  // Store lane enables and store data replicated onto every lane it may hit.
  always_comb begin
    w_be   = 4'b0000;
    w_wdat = wd;
    case (size_t'(size))
      SZ_BYTE: begin
        w_be   = 4'b0001 << w_lane;
        w_wdat = {4{wd[7:0]}};
      end
      SZ_HALF: begin
        w_be   = a[1] ? 4'b1100 : 4'b0011;
        w_wdat = {2{wd[15:0]}};
      end
      SZ_WORD: w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  // Load path: extract byte/half at the lane and extend; illegal loads read 0.
  always_comb begin
    w_word = r_mem[w_idx];
    w_byte = w_word[{w_lane, 3'b000} +: 8];
    w_half = a[1] ? w_word[31:16] : w_word[15:0];
    w_load = w_word;
    case (size_t'(size))
      SZ_BYTE: w_load = {{24{sext & w_byte[7]}}, w_byte};
      SZ_HALF: w_load = {{16{sext & w_half[15]}}, w_half};
      default: w_load = w_word;
    endcase
    if (w_illegal) w_load = '0;
  end

  // Array write port: zero-fill during the sweep, lane-masked stores in RUN.
  // NOTE: the array has no reset; its contents are defined by the sweep, and
  // leaving it out of the reset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_mem[r_ptr] <= '0;
    end else if (w_store) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdat[8*i +: 8];
      end
    end
  end

  // FSM state register and sweep pointer.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) r_ptr <= r_ptr + ADDR_W'(1);
    end
  end

  // FSM next state and Moore outputs; RUN is left only through reset.
  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    init_done   = 1'b0;
    case (r_state)
      ST_INIT: if (r_ptr == '1) w_state_nxt = ST_RUN;
      ST_RUN: begin
        ready     = 1'b1;
        init_done = 1'b1;
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Response registers: one strobe per accepted access, rd updated on loads only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rd     <= '0;
    end else begin
      r_rvalid <= w_acc;
      r_err    <= w_acc & w_illegal;
      if (w_acc && !we) r_rd <= w_load;
    end
  end

  assign rvalid = r_rvalid;
  assign err    = r_err;
  assign rd     = r_rd;

endmodule
